// File: rtl/logo_motion_ctrl.sv
// Bouncing-logo motion controller: once per frame it applies host settings, steps the
// logo position with wall bounce, and optionally advances the logo colour through a palette.
module logo_motion_ctrl #(
   parameter int VIEW_X_SIZE = 640,
   parameter int VIEW_Y_SIZE = 480,
   parameter int LOGO_X_SIZE = 256,
   parameter int LOGO_Y_SIZE = 148
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_begin,
   input  logic        cfg_write,
   input  logic [2:0]  cfg_addr,
   input  logic [23:0] cfg_data,
   output logic        cfg_ready,
   output logic [9:0]  pos_x,
   output logic [8:0]  pos_y,
   output logic [23:0] logo_color,
   output logic        bounce,
   output logic        frame_overrun
);

   localparam logic [10:0] X_MIN = 11'd1;
   localparam logic [10:0] X_MAX = 11'(VIEW_X_SIZE - LOGO_X_SIZE - 2);
   localparam logic [10:0] Y_MIN = 11'd1;
   localparam logic [10:0] Y_MAX = 11'(VIEW_Y_SIZE - LOGO_Y_SIZE - 2);

   typedef enum logic [1:0] {IDLE, APPLY, MOVE, COLOR} state_t;

   state_t      state_q, state_d;
   logic        inApply, inMove, inColor;
   logic        cfgAccept, wrCtrl, wrPos, wrPalette;
   logic [1:0]  palWrIdx;

   logic        shRun_q, shColorOnBounce_q, shValid_q;
   logic [2:0]  shSpeedX_q, shSpeedY_q;
   logic [9:0]  shPosX_q;
   logic [8:0]  shPosY_q;

   logic        run_q, colorOnBounce_q;
   logic [2:0]  speedX_q, speedY_q;

   logic [9:0]  workX_q, workX_d;
   logic [8:0]  workY_q, workY_d;
   logic        dirX_q, dirX_d, dirY_q, dirY_d;
   logic        hit_q, hit_d;
   logic [12:0] stepX, stepY;
   logic [10:0] loadX, loadY;
   logic        unusedBits;

   logic [23:0] palette_q [4];
   logic [1:0]  idx_q;
   logic        upd_q;

   // One axis step; direction 1 means travelling toward MIN. Returns {hit, dir, pos}.
   function automatic logic [12:0] axisStep(input logic [10:0] pos, input logic dirNeg,
                                            input logic [2:0] spd, input logic [10:0] lo,
                                            input logic [10:0] hi);
      logic [10:0] s11;
      logic [10:0] sum;
      s11 = {8'd0, spd};
      sum = pos + s11;
      axisStep = {1'b0, dirNeg, pos};
      if (spd != 3'd0) begin
         if (!dirNeg) begin
            if (sum >= hi) axisStep = {1'b1, 1'b1, hi};
            else           axisStep = {1'b0, 1'b0, sum};
         end else begin
            if (pos <= lo + s11) axisStep = {1'b1, 1'b0, lo};
            else                 axisStep = {1'b0, 1'b1, pos - s11};
         end
      end
   endfunction

   function automatic logic [10:0] clampAxis(input logic [10:0] v, input logic [10:0] lo,
                                             input logic [10:0] hi);
      if (v < lo)      clampAxis = lo;
      else if (v > hi) clampAxis = hi;
      else             clampAxis = v;
   endfunction

   // Frame sequencer state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Each non-idle step lasts one cycle; only a strobe seen in IDLE starts a frame
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (frame_begin) state_d = APPLY;
         APPLY: state_d = MOVE;
         MOVE:  state_d = COLOR;
         COLOR: state_d = IDLE;
      endcase
   end

   always_comb begin
      cfg_ready = 1'b0;
      inApply   = 1'b0;
      inMove    = 1'b0;
      inColor   = 1'b0;
      case (state_q)
         IDLE:  cfg_ready = 1'b1;
         APPLY: inApply   = 1'b1;
         MOVE:  inMove    = 1'b1;
         COLOR: inColor   = 1'b1;
      endcase
   end

   assign cfgAccept = cfg_write & cfg_ready;
   assign wrCtrl    = cfgAccept && (cfg_addr == 3'd0);
   assign wrPos     = cfgAccept && (cfg_addr == 3'd1);
   assign wrPalette = cfgAccept && (cfg_addr >= 3'd2) && (cfg_addr <= 3'd5);
   assign palWrIdx  = cfg_addr[1:0] - 2'd2;

   // Shadow copies of CTRL and POS_LOAD; the pending load is consumed in APPLY
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shRun_q           <= 1'b0;
         shSpeedX_q        <= 3'd1;
         shSpeedY_q        <= 3'd1;
         shColorOnBounce_q <= 1'b1;
         shPosX_q          <= 10'd0;
         shPosY_q          <= 9'd0;
         shValid_q         <= 1'b0;
      end else begin
         if (wrCtrl) begin
            shRun_q           <= cfg_data[0];
            shSpeedX_q        <= cfg_data[3:1];
            shSpeedY_q        <= cfg_data[6:4];
            shColorOnBounce_q <= cfg_data[7];
         end
         if (wrPos) begin
            shPosX_q  <= cfg_data[9:0];
            shPosY_q  <= cfg_data[18:10];
            shValid_q <= cfg_data[19];
         end else if (inApply) begin
            shValid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         palette_q[0] <= 24'hFFFFFF;
         palette_q[1] <= 24'hFF0000;
         palette_q[2] <= 24'h00FF00;
         palette_q[3] <= 24'h0000FF;
      end else if (wrPalette) begin
         palette_q[palWrIdx] <= cfg_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run_q           <= 1'b0;
         speedX_q        <= 3'd1;
         speedY_q        <= 3'd1;
         colorOnBounce_q <= 1'b1;
      end else if (inApply) begin
         run_q           <= shRun_q;
         speedX_q        <= shSpeedX_q;
         speedY_q        <= shSpeedY_q;
         colorOnBounce_q <= shColorOnBounce_q;
      end
   end

   // Working position: loaded (clamped) in APPLY, stepped in MOVE; 11-bit math avoids wrap
   always_comb begin
      stepX   = axisStep({1'b0, workX_q}, dirX_q, speedX_q, X_MIN, X_MAX);
      stepY   = axisStep({2'b00, workY_q}, dirY_q, speedY_q, Y_MIN, Y_MAX);
      loadX   = clampAxis({1'b0, shPosX_q}, X_MIN, X_MAX);
      loadY   = clampAxis({2'b00, shPosY_q}, Y_MIN, Y_MAX);
      workX_d = workX_q;
      workY_d = workY_q;
      dirX_d  = dirX_q;
      dirY_d  = dirY_q;
      hit_d   = hit_q;
      if (inApply) begin
         hit_d = 1'b0;
         if (shValid_q) begin
            workX_d = loadX[9:0];
            workY_d = loadY[8:0];
         end
      end else if (inMove && run_q) begin
         workX_d = stepX[9:0];
         workY_d = stepY[8:0];
         dirX_d  = stepX[11];
         dirY_d  = stepY[11];
         hit_d   = stepX[12] | stepY[12];
      end
   end

   assign unusedBits = ^{stepX[10], stepY[10:9], loadX[10], loadY[10:9]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         workX_q <= 10'd1;
         workY_q <= 9'd1;
         dirX_q  <= 1'b0;
         dirY_q  <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         workX_q <= workX_d;
         workY_q <= workY_d;
         dirX_q  <= dirX_d;
         dirY_q  <= dirY_d;
         hit_q   <= hit_d;
      end
   end

   // A corner hit sets the single hit flag, so the palette advances at most once per frame
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_q <= 2'd0;
         upd_q <= 1'b0;
      end else begin
         if (inColor && hit_q && colorOnBounce_q) idx_q <= idx_q + 2'd1;
         upd_q <= inColor;
      end
   end

   // Visible outputs all change on the same edge, four edges after the accepted strobe
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pos_x      <= 10'd1;
         pos_y      <= 9'd1;
         logo_color <= 24'hFFFFFF;
         bounce     <= 1'b0;
      end else if (upd_q) begin
         pos_x      <= workX_q;
         pos_y      <= workY_q;
         logo_color <= palette_q[idx_q];
         bounce     <= hit_q;
      end else begin
         bounce     <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                          frame_overrun <= 1'b0;
      else if (frame_begin && !cfg_ready) frame_overrun <= 1'b1;
      else if (wrCtrl && cfg_data[8])     frame_overrun <= 1'b0;
   end

endmodule
